// File: rtl/zbt_port_arbiter_pkg.sv
// Shared types and defaults for the ZBT port arbiter slice.
package zbt_port_arbiter_pkg;

    localparam int DEF_ADDR_W  = 19;
    localparam int DEF_DATA_W  = 36;
    localparam int DEF_ZBT_LAT = 2;

    // Operation on the ZBT port during the current cycle
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/zbt_wr_fifo.sv
// Write-request FIFO holding {addr,data} pairs; head is visible combinationally.
module zbt_wr_fifo
    import zbt_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [ADDR_W-1:0]       push_addr,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [ADDR_W-1:0]       head_addr,
    output logic [DATA_W-1:0]       head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;

    // Storage array; no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign {head_addr, head_data} = mem[rd_ptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/zbt_port_arbiter.sv
// Shares one ZBT SRAM port between buffered camera writes and display reads.
module zbt_port_arbiter
    import zbt_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WFIFO_DEPTH = 4,
    parameter int ZBT_LAT     = DEF_ZBT_LAT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_grant,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(WFIFO_DEPTH):0]  wfifo_level,
    output logic [7:0]                    overflow_cnt
);

    // Number of consecutive full-FIFO denials after which a read is forced through
    localparam logic [1:0] MAX_DENY = 2'd2;

    arb_state_t        state;
    arb_state_t        next_state;
    logic [1:0]        deny_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] wdata_pipe [ZBT_LAT+1];
    logic [ZBT_LAT:0]  rvalid_pipe;

    zbt_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (wfifo_level)
    );

    // Arbitration: full FIFO beats reads unless the reader has been starved
    always_comb begin
        next_state = ARB_IDLE;
        rd_grant   = 1'b0;
        if (fifo_full && !(rd_req && deny_cnt == MAX_DENY)) begin
            next_state = ARB_WR;
        end else if (rd_req) begin
            next_state = ARB_RD;
            rd_grant   = 1'b1;
        end else if (!fifo_empty) begin
            next_state = ARB_WR;
        end
    end

    assign pop  = (next_state == ARB_WR);
    assign push = wr_req && (!fifo_full || pop);
    assign drop = wr_req && fifo_full && !pop;

    // State register and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            deny_cnt <= '0;
        end else begin
            state <= next_state;
            if (rd_grant || !rd_req) begin
                deny_cnt <= '0;
            end else if (deny_cnt != MAX_DENY) begin
                deny_cnt <= deny_cnt + 2'd1;
            end
        end
    end

    assign mem_we = (state == ARB_WR);

    // Registered ZBT address; holds across idle cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
        end else if (next_state == ARB_RD) begin
            mem_addr <= rd_addr;
        end else if (next_state == ARB_WR) begin
            mem_addr <= head_addr;
        end
    end

    // Write data: stage 0 aligns with mem_we, the tail lags it by ZBT_LAT cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= ZBT_LAT; i++) begin
                wdata_pipe[i] <= '0;
            end
        end else begin
            if (pop) wdata_pipe[0] <= head_data;
            for (int unsigned i = 1; i <= ZBT_LAT; i++) begin
                wdata_pipe[i] <= wdata_pipe[i-1];
            end
        end
    end

    assign mem_wdata = wdata_pipe[ZBT_LAT];

    // Read return: grant travels with the ZBT pipeline, then captures mem_rdata
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_pipe <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            rvalid_pipe <= {rvalid_pipe[ZBT_LAT-1:0], rd_grant};
            rd_valid    <= rvalid_pipe[ZBT_LAT];
            if (rvalid_pipe[ZBT_LAT]) rd_data <= mem_rdata;
        end
    end

    // Saturating count of writes lost to a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_cnt <= '0;
        end else if (drop) begin
            overflow_cnt <= sat_inc8(overflow_cnt);
        end
    end

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Self-checking bench: directed vector table, corner sequences, random traffic
// against a queue-based reference model and a behavioural ZBT memory.
module tb_zbt_port_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 36;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int NVEC  = 22;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_grant;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [2:0]    wfifo_level;
    logic [7:0]    overflow_cnt;

    always #5 clk = ~clk;

    zbt_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WFIFO_DEPTH (DEPTH),
        .ZBT_LAT     (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_grant     (rd_grant),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .wfifo_level  (wfifo_level),
        .overflow_cnt (overflow_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ZBT memory: read data for an address appears LAT cycles after that address
    function automatic logic [DW-1:0] zmem(input logic [AW-1:0] a);
        if (a == 19'h00040) return 36'h0_0000_A5A5;
        return {a[16:0], ~a};
    endfunction

    logic [AW-1:0] zp1_addr = '0;
    logic [AW-1:0] zp2_addr = '0;
    logic          zp1_rd = 1'b0;
    logic          zp2_rd = 1'b0;

    // Memory responder, updated mid-cycle so the DUT samples stable data
    always @(negedge clk) begin
        mem_rdata = zp2_rd ? zmem(zp2_addr) : 36'h0_DEAD_BEEF;
        zp2_addr  = zp1_addr;
        zp2_rd    = zp1_rd;
        zp1_addr  = mem_addr;
        zp1_rd    = !mem_we;
    end

    // Reference model: pending writes as a queue, outcomes scheduled by cycle
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] exp_wd [int];
    logic [DW-1:0] exp_rv [int];
    int            streak = 0;
    int            m_ovf = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          last_denied = 1'b0;

    task automatic step(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic rr, input logic [AW-1:0] ra);
        bit grant;
        bit issue;
        @(negedge clk);
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rr;
        rd_addr = ra;
        #1;
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("wfifo_level", wfifo_level, wq.size());
        check("overflow_cnt", overflow_cnt, m_ovf);
        check("rd_valid", rd_valid, exp_rv.exists(cyc) ? 1 : 0);
        if (exp_rv.exists(cyc)) m_rdata = exp_rv[cyc];
        check("rd_data", rd_data, m_rdata);
        if (exp_wd.exists(cyc)) check("mem_wdata", mem_wdata, exp_wd[cyc]);

        grant = rr && (wq.size() < DEPTH || streak >= 2);
        issue = !grant && wq.size() > 0;
        check("rd_grant", rd_grant, grant);
        m_we = issue;
        if (grant) begin
            m_addr = ra;
            exp_rv[cyc + 2 + LAT] = zmem(ra);
        end
        if (issue) begin
            m_addr = wq[0].a;
            exp_wd[cyc + 1 + LAT] = wq[0].d;
            void'(wq.pop_front());
        end
        streak = grant ? 0 : (rr ? streak + 1 : 0);
        if (wr) begin
            if (wq.size() < DEPTH) wq.push_back(wr_t'{a: wa, d: wd});
            else if (m_ovf < 255) m_ovf++;
        end
        last_denied = rr && !grant;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_level", wfifo_level, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ovf", overflow_cnt, 0);
        wq.delete();
        exp_wd.delete();
        exp_rv.delete();
        streak      = 0;
        m_ovf       = 0;
        m_addr      = '0;
        m_we        = 1'b0;
        m_rdata     = '0;
        last_denied = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rd;
        logic [AW-1:0] ra;
        logic          e_grant;
        int            e_level;
        logic          e_we;
        logic [AW-1:0] e_addr;
        int            e_ovf;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic wr, input int wa, input logic rd, input int ra,
                                input logic g, input int lvl, input logic we, input int ad,
                                input int ovf);
        vec_t v;
        v.wr      = wr;
        v.wa      = AW'(wa);
        v.wd      = {4'hC, 13'h0, AW'(wa)};
        v.rd      = rd;
        v.ra      = AW'(ra);
        v.e_grant = g;
        v.e_level = lvl;
        v.e_we    = we;
        v.e_addr  = AW'(ad);
        v.e_ovf   = ovf;
        return v;
    endfunction

    initial begin
        logic          rr;
        logic [AW-1:0] ra;
        logic [AW-1:0] held_ra;
        int            wr_pct;
        int            rd_pct;

        //              wr  wa     rd  ra     grant lvl we addr   ovf
        vecs[0]  = mk(1, 'h200, 1, 'h100, 1, 0, 0, 'h000, 0);
        vecs[1]  = mk(1, 'h201, 1, 'h101, 1, 1, 0, 'h100, 0);
        vecs[2]  = mk(1, 'h202, 1, 'h102, 1, 2, 0, 'h101, 0);
        vecs[3]  = mk(0, 'h000, 1, 'h103, 1, 3, 0, 'h102, 0);
        vecs[4]  = mk(0, 'h000, 0, 'h000, 0, 3, 0, 'h103, 0);
        vecs[5]  = mk(0, 'h000, 0, 'h000, 0, 2, 1, 'h200, 0);
        vecs[6]  = mk(0, 'h000, 0, 'h000, 0, 1, 1, 'h201, 0);
        vecs[7]  = mk(0, 'h000, 0, 'h000, 0, 0, 1, 'h202, 0);
        vecs[8]  = mk(0, 'h000, 0, 'h000, 0, 0, 0, 'h202, 0);
        vecs[9]  = mk(1, 'h210, 1, 'h110, 1, 0, 0, 'h202, 0);
        vecs[10] = mk(1, 'h211, 1, 'h111, 1, 1, 0, 'h110, 0);
        vecs[11] = mk(1, 'h212, 1, 'h112, 1, 2, 0, 'h111, 0);
        vecs[12] = mk(1, 'h213, 1, 'h113, 1, 3, 0, 'h112, 0);
        vecs[13] = mk(1, 'h214, 1, 'h114, 0, 4, 0, 'h113, 0);
        vecs[14] = mk(1, 'h215, 1, 'h114, 0, 4, 1, 'h210, 0);
        vecs[15] = mk(1, 'h216, 1, 'h114, 1, 4, 1, 'h211, 0);
        vecs[16] = mk(0, 'h000, 0, 'h000, 0, 4, 0, 'h114, 1);
        vecs[17] = mk(0, 'h000, 0, 'h000, 0, 3, 1, 'h212, 1);
        vecs[18] = mk(0, 'h000, 0, 'h000, 0, 2, 1, 'h213, 1);
        vecs[19] = mk(0, 'h000, 0, 'h000, 0, 1, 1, 'h214, 1);
        vecs[20] = mk(0, 'h000, 0, 'h000, 0, 0, 1, 'h215, 1);
        vecs[21] = mk(0, 'h000, 0, 'h000, 0, 0, 0, 'h215, 1);

        do_reset();

        // Contention and full-FIFO starvation table
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra);
            check($sformatf("vec%0d_grant", i), rd_grant, vecs[i].e_grant);
            check($sformatf("vec%0d_level", i), wfifo_level, vecs[i].e_level);
            check($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_ovf", i), overflow_cnt, vecs[i].e_ovf);
        end

        // Single write: address at +2, data at +4
        step(1'b1, 19'h00123, 36'h9_ABCD_1234, 1'b0, '0);
        idle(2);
        check("t1_we", mem_we, 1);
        check("t1_addr", mem_addr, 19'h00123);
        idle(1);
        check("t1_we_pulse", mem_we, 0);
        idle(1);
        check("t1_wdata", mem_wdata, 36'h9_ABCD_1234);

        // Single read: data strobed exactly 4 cycles after the request
        step(1'b0, '0, '0, 1'b1, 19'h00040);
        check("t2_grant", rd_grant, 1);
        idle(3);
        check("t2_valid_early", rd_valid, 0);
        idle(1);
        check("t2_valid", rd_valid, 1);
        check("t2_data", rd_data, 36'h0_0000_A5A5);
        idle(1);
        check("t2_valid_pulse", rd_valid, 0);
        check("t2_data_hold", rd_data, 36'h0_0000_A5A5);

        // Saturation of the overflow counter under constant write and read pressure
        do_reset();
        for (int i = 0; i < 960; i++) begin
            step(1'b1, AW'($urandom), DW'({$urandom, $urandom}), 1'b1, 19'h00007);
        end
        check("t5_ovf_sat", overflow_cnt, 255);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, AW'($urandom), DW'({$urandom, $urandom}), 1'b1, 19'h00007);
        end
        check("t5_ovf_stays", overflow_cnt, 255);
        idle(6);

        // Reset one cycle after a read grant, two writes queued
        do_reset();
        step(1'b1, 19'h00300, 36'h1_1111_1111, 1'b1, 19'h00120);
        step(1'b1, 19'h00301, 36'h2_2222_2222, 1'b1, 19'h00121);
        step(1'b0, '0, '0, 1'b1, 19'h00122);
        check("t6_level_before", wfifo_level, 2);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            check($sformatf("t6_no_valid%0d", i), rd_valid, 0);
        end

        // Random traffic in three pressure regimes
        do_reset();
        held_ra = '0;
        for (int ph = 0; ph < 3; ph++) begin
            wr_pct = (ph == 0) ? 30 : (ph == 1) ? 75 : 20;
            rd_pct = (ph == 0) ? 50 : (ph == 1) ? 85 : 10;
            for (int i = 0; i < 700; i++) begin
                if (last_denied) begin
                    rr = 1'b1;
                    ra = held_ra;
                end else begin
                    rr = ($urandom_range(0, 99) < rd_pct);
                    ra = AW'($urandom);
                end
                held_ra = ra;
                step(($urandom_range(0, 99) < wr_pct), AW'($urandom),
                     DW'({$urandom, $urandom}), rr, ra);
            end
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zbt_port_arbiter.md
Name: zbt_port_arbiter

Overview:
- Shares the single ZBT SRAM port between two requesters: the camera write path (paired-pixel words with address and write strobe) and the display read path (pixel fetch requests).
- Each cycle issues at most one memory operation.
- Buffers write pulses in a small FIFO so that writes never collide with display reads.
- Generates ZBT pipeline timing: write data follows its address by 2 cycles, and a valid strobe is aligned with returned read data.

Parameters:
ADDR_W, 19, ZBT word address width
DATA_W, 36, ZBT data width
WFIFO_DEPTH, 4, write FIFO entries (power of two, >= 2)
ZBT_LAT, 2, ZBT pipeline depth, in cycles, for read data and for write data

Ports:
clk  in  1  system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
wr_req  in  1  single-cycle write request from the camera path
wr_addr  in  ADDR_W  write address, sampled when wr_req=1
wr_data  in  DATA_W  write data, sampled when wr_req=1
rd_req  in  1  display read request
rd_addr  in  ADDR_W  read address, sampled when rd_req=1
rd_grant  out  1  combinational; high when rd_req is accepted this cycle
rd_data  out  DATA_W  read data, valid when rd_valid=1
rd_valid  out  1  read-data strobe
mem_addr  out  ADDR_W  registered ZBT address
mem_we  out  1  registered ZBT write enable, active high
mem_wdata  out  DATA_W  ZBT write data, driven ZBT_LAT cycles after its mem_we
mem_rdata  in  DATA_W  ZBT read data bus
wfifo_level  out  clog2(WFIFO_DEPTH)+1  current FIFO occupancy
overflow_cnt  out  8  count of dropped writes, saturating

Behaviour:
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, rd_data=0, rd_valid=0, overflow_cnt=0. FIFO is empty; all delay lines are cleared.
- Reset asserted mid-operation discards in-flight reads and pending writes. No rd_valid is produced for those reads.
- Arbitration state is a registered 3-state FSM giving the operation issued this cycle:
  - IDLE: no operation.
  - RD: read issued.
  - WR: write issued.
- Next-state decision, evaluated every cycle:
  - If FIFO is full and non-empty → WR, and rd_grant=0. Full FIFO beats reading, so no write is lost.
  - Else if rd_req → RD, rd_grant=1.
  - Else if FIFO is non-empty → WR.
  - Else → IDLE.
- Starvation guard: after 2 consecutive WR-forced denials, a pending rd_req wins the next cycle even if the FIFO is full. The resulting overflow is counted.
- Display requester contract: a denied rd_req is re-presented next cycle, with rd_addr held.
- Memory outputs are registered, so the operation is visible 1 cycle after the decision:
  - RD: mem_addr<=rd_addr, mem_we<=0.
  - WR: pop the FIFO head; mem_addr<=head addr, mem_we<=1.
  - IDLE: mem_we<=0, mem_addr holds its value.
- Write data: the popped data enters a ZBT_LAT-deep delay line and drives mem_wdata exactly ZBT_LAT cycles after the corresponding mem_we=1 cycle.
- Read return:
  - A valid bit enters a (1+ZBT_LAT)-deep shift register on the grant.
  - rd_valid=1 and rd_data<=mem_rdata, registered, exactly 2+ZBT_LAT cycles after the accepted rd_req (4 at default).
  - rd_data holds its value otherwise.
- Write FIFO behaviour:
  - Push on wr_req when not full. Simultaneous push and pop on a full FIFO is accepted.
  - wr_req when full with no pop in the same cycle: the write is dropped and overflow_cnt increments, saturating at 255.
  - Pointers wrap modulo WFIFO_DEPTH. wfifo_level ranges 0..WFIFO_DEPTH.
  - Ordering is strict FIFO. Writes never reorder with respect to each other.
- Read-after-write to the same address gives no ordering guarantee; the display path tolerates stale pixels.

Decomposition:
- Shared package contains:
  - arbitration state encoding: ARB_IDLE=2'd0, ARB_RD=2'd1, ARB_WR=2'd2;
  - ZBT_LAT;
  - default ADDR_W and DATA_W.
- One sub-module: zbt_wr_fifo, a synchronous FIFO with push, pop, full, empty, level, and asynchronous reset. It stores {addr,data}.

Test Plan:
1. Single write: wr_req with addr=0x00123, data=0x9_ABCD_1234, no reads → mem_we=1 with mem_addr=0x00123 at cycle+2; mem_wdata=0x9ABCD1234 at cycle+4.
2. Single read: rd_req with addr=0x00040; the bench returns mem_rdata=0xA5A5 when mem_addr=0x40 appears → rd_valid=1 with rd_data=0xA5A5 exactly 4 cycles after the request.
3. Contention: rd_req held high continuously while 3 write pulses arrive → all reads granted, wfifo_level reaches 3 and no writes issue. When rd_req drops, 3 consecutive WR cycles issue in order.
4. Full FIFO: 4 queued writes plus continuous rd_req → rd_grant=0 for up to 2 cycles, then a read is forced. A 5th wr_req arriving on a no-pop cycle → overflow_cnt=1.
5. Saturation: 300 dropped writes → overflow_cnt=255 and stays there.
6. Reset mid-operation: assert reset 1 cycle after a read grant while 2 writes are queued → rd_valid never asserts, mem_we=0, wfifo_level=0 immediately, without waiting for a clock edge.
